// File: rtl/iec_bus_hub.sv
// IEC serial-bus hub: merges host, external and emulated-drive pull-downs,
// glitch-filters the bus lines and generates the drive phase strobes.
module iec_bus_hub #(
    parameter int NUM_DRIVES = 2,
    parameter int FILTER_LEN = 2,
    parameter int CLK_DIV    = 32
) (
    input  logic                  clk32,
    input  logic                  reset_n,
    input  logic                  host_atn,
    input  logic                  host_clk,
    input  logic                  host_data,
    input  logic                  ext_atn,
    input  logic                  ext_clk,
    input  logic                  ext_data,
    input  logic [NUM_DRIVES-1:0] drv_en,
    input  logic [NUM_DRIVES-1:0] drv_clk_o,
    input  logic [NUM_DRIVES-1:0] drv_data_o,
    input  logic [NUM_DRIVES-1:0] drv_atna,
    input  logic [1:0]            speed,
    output logic                  atn_f,
    output logic                  clk_f,
    output logic                  data_f,
    output logic                  atn_stb,
    output logic [23:0]           glitch_cnt,
    output logic                  ph_rise,
    output logic                  ph_fall
);

    // The incoming raw sample acts as the newest history entry, so only
    // FILTER_LEN-1 older samples need storing once FILTER_LEN exceeds one.
    localparam int HD = (FILTER_LEN > 1) ? FILTER_LEN - 1 : 1;

    logic                  raw_atn;
    logic [NUM_DRIVES-1:0] drv_clk_term;
    logic [NUM_DRIVES-1:0] drv_data_term;
    logic [2:0]            raw;
    logic [2:0]            filt_reg;
    logic [2:0]            filt_next;

    assign raw_atn = host_atn | ext_atn;

    // ATN-ack uses the unfiltered ATN so DATA hold-off follows in the same cycle.
    for (genvar gi = 0; gi < NUM_DRIVES; gi++) begin : g_drv
        assign drv_clk_term[gi]  = drv_en[gi] & drv_clk_o[gi];
        assign drv_data_term[gi] = drv_en[gi] & (drv_data_o[gi] | (drv_atna[gi] ^ raw_atn));
    end

    assign raw = {raw_atn,
                  host_clk  | ext_clk  | (|drv_clk_term),
                  host_data | ext_data | (|drv_data_term)};

    // Line index: 2 = ATN, 1 = CLK, 0 = DATA.
    for (genvar gi = 0; gi < 3; gi++) begin : g_line
        logic [HD-1:0] hist_reg;
        logic [HD-1:0] hist_next;
        logic [7:0]    cnt_reg;
        logic          settled;
        logic          next_val;
        logic          upd;
        logic          glitch;

        if (FILTER_LEN > 1) begin : g_deep
            assign settled  = (&{hist_reg, raw[gi]}) | ~(|{hist_reg, raw[gi]});
            assign next_val = raw[gi];
        end else begin : g_single
            assign settled  = 1'b1;
            assign next_val = hist_reg[0];
        end

        if (HD > 1) begin : g_shift
            assign hist_next = {hist_reg[HD-2:0], raw[gi]};
        end else begin : g_one
            assign hist_next = raw[gi];
        end

        assign upd           = settled & (next_val != filt_reg[gi]);
        assign filt_next[gi] = upd ? next_val : filt_reg[gi];
        // An excursion that returns to the filtered level without ever being accepted.
        assign glitch        = (hist_reg[0] != filt_reg[gi]) & (raw[gi] == filt_reg[gi]) & ~upd;

        always_ff @(posedge clk32 or negedge reset_n) begin
            if (!reset_n) begin
                hist_reg     <= '0;
                filt_reg[gi] <= 1'b0;
                cnt_reg      <= 8'd0;
            end else begin
                hist_reg     <= hist_next;
                filt_reg[gi] <= filt_next[gi];
                if (glitch && cnt_reg != 8'hFF)
                    cnt_reg <= cnt_reg + 8'd1;
            end
        end

        assign glitch_cnt[8*gi +: 8] = cnt_reg;
    end

    assign atn_f  = filt_reg[2];
    assign clk_f  = filt_reg[1];
    assign data_f = filt_reg[0];

    always_ff @(posedge clk32 or negedge reset_n) begin
        if (!reset_n)
            atn_stb <= 1'b0;
        else
            atn_stb <= filt_next[2] & ~filt_reg[2];
    end

    logic [5:0] div_reg;
    logic [6:0] p_reg;
    logic [6:0] p_sel;
    logic       wrap;

    always_comb begin
        p_sel = 7'(CLK_DIV);
        case (speed)
            2'd1:    p_sel = 7'(CLK_DIV / 2);
            2'd2:    p_sel = 7'(CLK_DIV / 4);
            default: p_sel = 7'(CLK_DIV);
        endcase
    end

    assign wrap = ({1'b0, div_reg} == (p_reg - 7'd1));

    // The period is only re-latched on wrap, so a speed change never truncates a period.
    always_ff @(posedge clk32 or negedge reset_n) begin
        if (!reset_n) begin
            div_reg <= 6'd0;
            p_reg   <= 7'(CLK_DIV);
            ph_rise <= 1'b0;
            ph_fall <= 1'b0;
        end else begin
            ph_rise <= (div_reg == 6'd0);
            ph_fall <= (div_reg == p_reg[6:1]);
            if (wrap) begin
                div_reg <= 6'd0;
                p_reg   <= p_sel;
            end else begin
                div_reg <= div_reg + 6'd1;
            end
        end
    end

endmodule

// File: tb/tb_iec_bus_hub.sv
// Directed bench for iec_bus_hub with default parameters (2 drives, filter 2, divisor 32).
module tb_iec_bus_hub;

    logic        clk32 = 1'b0;
    logic        reset_n;
    logic        host_atn, host_clk, host_data;
    logic        ext_atn, ext_clk, ext_data;
    logic [1:0]  drv_en, drv_clk_o, drv_data_o, drv_atna;
    logic [1:0]  speed;
    logic        atn_f, clk_f, data_f, atn_stb;
    logic [23:0] glitch_cnt;
    logic        ph_rise, ph_fall;

    int checks   = 0;
    int failures = 0;

    iec_bus_hub #(.NUM_DRIVES(2), .FILTER_LEN(2), .CLK_DIV(32)) dut (
        .clk32(clk32), .reset_n(reset_n),
        .host_atn(host_atn), .host_clk(host_clk), .host_data(host_data),
        .ext_atn(ext_atn), .ext_clk(ext_clk), .ext_data(ext_data),
        .drv_en(drv_en), .drv_clk_o(drv_clk_o), .drv_data_o(drv_data_o), .drv_atna(drv_atna),
        .speed(speed),
        .atn_f(atn_f), .clk_f(clk_f), .data_f(data_f), .atn_stb(atn_stb),
        .glitch_cnt(glitch_cnt), .ph_rise(ph_rise), .ph_fall(ph_fall)
    );

    always #5 clk32 = ~clk32;

    task automatic tick();
        @(posedge clk32);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        host_atn = 0; host_clk = 0; host_data = 0;
        ext_atn = 0; ext_clk = 0; ext_data = 0;
        drv_en = 2'b00; drv_clk_o = 2'b00; drv_data_o = 2'b00; drv_atna = 2'b00;
        speed = 2'd0;
        repeat (3) tick();
        checks++;
        if ({atn_f, clk_f, data_f, atn_stb, ph_rise, ph_fall} !== 6'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=000000", {atn_f, clk_f, data_f, atn_stb, ph_rise, ph_fall});
        end
        checks++;
        if (glitch_cnt !== 24'd0) begin
            failures++;
            $display("FAIL reset_glitch_cnt got=%h exp=000000", glitch_cnt);
        end
        $display("reset: outputs=%b glitch_cnt=%h", {atn_f, clk_f, data_f, atn_stb, ph_rise, ph_fall}, glitch_cnt);
    endtask

    task automatic test_phase();
        logic exp_r, exp_f;
        reset_n = 1'b1;
        for (int n = 1; n <= 70; n++) begin
            tick();
            exp_r = (n == 1) || (n == 33) || (n == 65);
            exp_f = (n == 17) || (n == 49);
            checks++;
            if (ph_rise !== exp_r || ph_fall !== exp_f) begin
                failures++;
                $display("FAIL phase_cycle%0d got rise=%b fall=%b exp rise=%b fall=%b", n, ph_rise, ph_fall, exp_r, exp_f);
            end
        end
        checks++;
        if ({atn_f, clk_f, data_f} !== 3'b000 || glitch_cnt !== 24'd0) begin
            failures++;
            $display("FAIL idle_bus got f=%b cnt=%h exp f=000 cnt=000000", {atn_f, clk_f, data_f}, glitch_cnt);
        end
        $display("phase: 70 cycles checked after reset release");
    endtask

    task automatic test_filter();
        host_clk = 1'b1;
        tick();
        host_clk = 1'b0;
        repeat (3) tick();
        checks++;
        if (clk_f !== 1'b0 || glitch_cnt !== 24'h000100) begin
            failures++;
            $display("FAIL clk_glitch got clk_f=%b cnt=%h exp clk_f=0 cnt=000100", clk_f, glitch_cnt);
        end
        $display("filter: one-cycle CLK pulse clk_f=%b cnt=%h", clk_f, glitch_cnt);

        host_clk = 1'b1;
        tick();
        checks++;
        if (clk_f !== 1'b0) begin
            failures++;
            $display("FAIL clk_latency1 got=%b exp=0", clk_f);
        end
        tick();
        checks++;
        if (clk_f !== 1'b1) begin
            failures++;
            $display("FAIL clk_latency2 got=%b exp=1", clk_f);
        end
        host_clk = 1'b0;
        tick();
        checks++;
        if (clk_f !== 1'b1) begin
            failures++;
            $display("FAIL clk_fall_hold got=%b exp=1", clk_f);
        end
        tick();
        checks++;
        if (clk_f !== 1'b0 || glitch_cnt !== 24'h000100) begin
            failures++;
            $display("FAIL clk_fall got clk_f=%b cnt=%h exp clk_f=0 cnt=000100", clk_f, glitch_cnt);
        end
        $display("filter: held CLK pulse rose and fell with two-cycle latency");
    endtask

    task automatic test_atn_ack();
        drv_en = 2'b01; drv_atna = 2'b00; host_atn = 1'b1;
        tick();
        checks++;
        if ({atn_f, data_f, atn_stb} !== 3'b000) begin
            failures++;
            $display("FAIL atn_latency1 got atn/data/stb=%b exp=000", {atn_f, data_f, atn_stb});
        end
        tick();
        checks++;
        if ({atn_f, data_f, atn_stb} !== 3'b111) begin
            failures++;
            $display("FAIL atn_latency2 got atn/data/stb=%b exp=111", {atn_f, data_f, atn_stb});
        end
        tick();
        checks++;
        if ({atn_f, data_f, atn_stb} !== 3'b110) begin
            failures++;
            $display("FAIL atn_stb_width got atn/data/stb=%b exp=110", {atn_f, data_f, atn_stb});
        end
        drv_atna = 2'b01;
        tick();
        tick();
        checks++;
        if (data_f !== 1'b0) begin
            failures++;
            $display("FAIL atna_ack got data_f=%b exp=0", data_f);
        end
        drv_atna = 2'b00;
        tick();
        tick();
        checks++;
        if (data_f !== 1'b1) begin
            failures++;
            $display("FAIL atna_clear got data_f=%b exp=1", data_f);
        end
        drv_en = 2'b00;
        tick();
        tick();
        checks++;
        if (data_f !== 1'b0) begin
            failures++;
            $display("FAIL drv_en_off got data_f=%b exp=0", data_f);
        end
        host_atn = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            tick();
            checks++;
            if (atn_stb !== 1'b0 || atn_f !== (n < 2)) begin
                failures++;
                $display("FAIL atn_release_cycle%0d got atn_f=%b stb=%b exp atn_f=%b stb=0", n, atn_f, atn_stb, (n < 2));
            end
        end
        $display("atn_ack: ATN with drive 0 connected, data hold-off and release checked");
    endtask

    task automatic test_atn_no_drive();
        drv_en = 2'b00; drv_atna = 2'b00; drv_clk_o = 2'b10; host_atn = 1'b1;
        for (int n = 1; n <= 3; n++) begin
            tick();
            checks++;
            if (data_f !== 1'b0 || clk_f !== 1'b0 || atn_f !== (n >= 2) || atn_stb !== (n == 2)) begin
                failures++;
                $display("FAIL no_drive_cycle%0d got atn/clk/data/stb=%b%b%b%b exp=%b00%b",
                         n, atn_f, clk_f, data_f, atn_stb, (n >= 2), (n == 2));
            end
        end
        drv_en = 2'b10;
        tick();
        tick();
        checks++;
        if (clk_f !== 1'b1 || data_f !== 1'b1) begin
            failures++;
            $display("FAIL drive1_enable got clk_f=%b data_f=%b exp 1 1", clk_f, data_f);
        end
        drv_en = 2'b00; drv_clk_o = 2'b00; host_atn = 1'b0;
        repeat (3) tick();
        checks++;
        if ({atn_f, clk_f, data_f} !== 3'b000 || glitch_cnt !== 24'h000100) begin
            failures++;
            $display("FAIL no_drive_idle got f=%b cnt=%h exp f=000 cnt=000100", {atn_f, clk_f, data_f}, glitch_cnt);
        end
        $display("no_drive: disconnected drives ignored, drive 1 connect checked");
    endtask

    task automatic test_speed_change();
        int  waited;
        logic exp_r, exp_f;
        waited = 0;
        while (ph_rise !== 1'b1 && waited < 100) begin
            tick();
            waited++;
        end
        checks++;
        if (ph_rise !== 1'b1) begin
            failures++;
            $display("FAIL speed_wait_rise got=%b exp=1 after %0d cycles", ph_rise, waited);
        end
        repeat (4) tick();
        speed = 2'd2;
        for (int n = 1; n <= 40; n++) begin
            tick();
            exp_r = (n == 28) || (n == 36);
            exp_f = (n == 12) || (n == 32) || (n == 40);
            checks++;
            if (ph_rise !== exp_r || ph_fall !== exp_f) begin
                failures++;
                $display("FAIL speed_cycle%0d got rise=%b fall=%b exp rise=%b fall=%b", n, ph_rise, ph_fall, exp_r, exp_f);
            end
        end
        speed = 2'd0;
        $display("speed: switch 0->2 at div=5 completed 32-cycle period then 8-cycle period");
    endtask

    task automatic test_glitch_sat();
        for (int n = 0; n < 300; n++) begin
            host_atn = 1'b1;
            tick();
            host_atn = 1'b0;
            tick();
            if (n == 99) begin
                checks++;
                if (glitch_cnt !== 24'h640100) begin
                    failures++;
                    $display("FAIL atn_glitch_100 got=%h exp=640100", glitch_cnt);
                end
            end
        end
        tick();
        checks++;
        if (glitch_cnt !== 24'hFF0100 || atn_f !== 1'b0 || atn_stb !== 1'b0) begin
            failures++;
            $display("FAIL atn_glitch_sat got cnt=%h atn_f=%b stb=%b exp cnt=ff0100 atn_f=0 stb=0", glitch_cnt, atn_f, atn_stb);
        end
        $display("glitch_sat: 300 ATN glitches cnt=%h", glitch_cnt);
    endtask

    task automatic test_async_reset();
        host_atn = 1'b1;
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({atn_f, clk_f, data_f, atn_stb, ph_rise, ph_fall} !== 6'b0 || glitch_cnt !== 24'd0) begin
            failures++;
            $display("FAIL async_reset got outputs=%b cnt=%h exp 000000 000000",
                     {atn_f, clk_f, data_f, atn_stb, ph_rise, ph_fall}, glitch_cnt);
        end
        for (int n = 1; n <= 3; n++) begin
            tick();
            checks++;
            if ({atn_f, atn_stb, ph_rise, ph_fall} !== 4'b0) begin
                failures++;
                $display("FAIL reset_hold_cycle%0d got atn/stb/rise/fall=%b exp=0000", n, {atn_f, atn_stb, ph_rise, ph_fall});
            end
        end
        reset_n = 1'b1;
        tick();
        checks++;
        if (ph_rise !== 1'b1 || ph_fall !== 1'b0) begin
            failures++;
            $display("FAIL rerelease_rise got rise=%b fall=%b exp rise=1 fall=0", ph_rise, ph_fall);
        end
        host_atn = 1'b0;
        $display("async_reset: mid-train reset cleared outputs, phase restarted");
    endtask

    initial begin
        test_reset();
        test_phase();
        test_filter();
        test_atn_ack();
        test_atn_no_drive();
        test_speed_change();
        test_glitch_sat();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
